// File: rtl/seq_alu_if.sv
// Handshake bundle between the decode/operand stage, seq_alu and writeback.
interface seq_alu_if #(
   parameter int unsigned WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       control;
   logic [WIDTH-1:0] input1;
   logic [WIDTH-1:0] input2;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             illegal;

   modport master (
      output in_valid, control, input1, input2, out_ready,
      input  in_ready, out_valid, result, zero, illegal
   );

   modport slave (
      input  in_valid, control, input1, input2, out_ready,
      output in_ready, out_valid, result, zero, illegal
   );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: 1-cycle logic/arith ops, iterative shifts and an optional
// shift-add multiplier enabled by defining SEQ_ALU_MUL_EN.
module seq_alu #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned SHIFT_STEP = 1
) (
   input  logic    clk,
   input  logic    rst,
   seq_alu_if.slave bus
);
   localparam int unsigned SHW = $clog2(WIDTH);
   localparam int unsigned CW  = SHW + 1;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
   typedef enum logic [1:0] {OP_SLL, OP_SRL, OP_SRA, OP_MUL} op_kind_t;

   state_t           r_state;
   state_t           w_state_next;
   op_kind_t         r_op;
   op_kind_t         w_op_kind;
   logic [WIDTH-1:0] r_acc;
   logic [CW-1:0]    r_rem;
   logic [WIDTH-1:0] r_result;
   logic             r_zero;
   logic             r_illegal;
   logic             r_in_ready;
   logic             r_out_valid;
`ifdef SEQ_ALU_MUL_EN
   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_mplier;
`endif

   logic             w_accept;
   logic [SHW-1:0]   w_shamt;
   logic             w_shift_op;
   logic             w_mul_op;
   logic [WIDTH-1:0] w_alu_res;
   logic             w_alu_illegal;
   logic [CW-1:0]    w_step;
   logic [WIDTH-1:0] w_acc_next;
   logic [CW-1:0]    w_rem_next;
   logic             w_start_busy;
   logic             w_finish;
   logic [WIDTH-1:0] w_fin_res;
   logic             w_fin_illegal;

   assign w_accept = bus.in_valid && r_in_ready;
   assign w_shamt  = bus.input2[SHW-1:0];

   // Single-cycle result and op decode; shifts here only cover shamt == 0.
   always_comb begin
      w_alu_res     = '0;
      w_alu_illegal = 1'b0;
      w_shift_op    = 1'b0;
      w_mul_op      = 1'b0;
      w_op_kind     = OP_SLL;
      case (bus.control)
         4'b0010: w_alu_res = bus.input1 + bus.input2;
         4'b0110: w_alu_res = bus.input1 - bus.input2;
         4'b0000: w_alu_res = bus.input1 & bus.input2;
         4'b0001: w_alu_res = bus.input1 | bus.input2;
         4'b0011: w_alu_res = bus.input1 ^ bus.input2;
         4'b0111: w_alu_res = {{(WIDTH-1){1'b0}},
                               ($signed(bus.input1) < $signed(bus.input2))};
         4'b1000: w_alu_res = {{(WIDTH-1){1'b0}}, (bus.input1 < bus.input2)};
         4'b0100: begin
            w_alu_res  = bus.input1;
            w_shift_op = 1'b1;
            w_op_kind  = OP_SLL;
         end
         4'b0101: begin
            w_alu_res  = bus.input1;
            w_shift_op = 1'b1;
            w_op_kind  = OP_SRL;
         end
         4'b1101: begin
            w_alu_res  = bus.input1;
            w_shift_op = 1'b1;
            w_op_kind  = OP_SRA;
         end
`ifdef SEQ_ALU_MUL_EN
         4'b1010: begin
            w_mul_op  = 1'b1;
            w_op_kind = OP_MUL;
         end
`endif
         default: begin
            w_alu_res     = WIDTH'(16'hCAFE);
            w_alu_illegal = 1'b1;
         end
      endcase
   end

   // One iteration of the shift or multiply datapath.
   always_comb begin
      w_step     = (r_rem < CW'(SHIFT_STEP)) ? r_rem : CW'(SHIFT_STEP);
      w_rem_next = r_rem - w_step;
      w_acc_next = r_acc;
      case (r_op)
         OP_SLL: w_acc_next = r_acc << w_step;
         OP_SRL: w_acc_next = r_acc >> w_step;
         OP_SRA: w_acc_next = WIDTH'($signed(r_acc) >>> w_step);
`ifdef SEQ_ALU_MUL_EN
         OP_MUL: begin
            w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
            w_rem_next = r_rem - CW'(1);
         end
`endif
         default: w_acc_next = r_acc;
      endcase
   end

   // Next-state logic and result-capture strobes.
   always_comb begin
      w_state_next  = r_state;
      w_start_busy  = 1'b0;
      w_finish      = 1'b0;
      w_fin_res     = w_alu_res;
      w_fin_illegal = w_alu_illegal;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if ((w_shift_op && (w_shamt != '0)) || w_mul_op) begin
                  w_state_next = S_BUSY;
                  w_start_busy = 1'b1;
               end else begin
                  w_state_next = S_DONE;
                  w_finish     = 1'b1;
               end
            end
         end
         S_BUSY: begin
            if (w_rem_next == '0) begin
               w_state_next  = S_DONE;
               w_finish      = 1'b1;
               w_fin_res     = w_acc_next;
               w_fin_illegal = 1'b0;
            end
         end
         S_DONE: begin
            if (bus.out_ready) w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_op        <= OP_SLL;
         r_acc       <= '0;
         r_rem       <= '0;
         r_result    <= '0;
         r_zero      <= 1'b1;
         r_illegal   <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
         r_mcand     <= '0;
         r_mplier    <= '0;
`endif
      end else begin
         r_state     <= w_state_next;
         r_in_ready  <= (w_state_next == S_IDLE);
         r_out_valid <= (w_state_next == S_DONE);
         if (w_start_busy) begin
            r_op <= w_op_kind;
`ifdef SEQ_ALU_MUL_EN
            if (w_mul_op) begin
               r_acc    <= '0;
               r_rem    <= CW'(WIDTH);
               r_mcand  <= bus.input1;
               r_mplier <= bus.input2;
            end else begin
               r_acc <= bus.input1;
               r_rem <= CW'(w_shamt);
            end
`else
            r_acc <= bus.input1;
            r_rem <= CW'(w_shamt);
`endif
         end else if (r_state == S_BUSY) begin
            r_acc <= w_acc_next;
            r_rem <= w_rem_next;
`ifdef SEQ_ALU_MUL_EN
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
`endif
         end
         // zero is derived only from the value that becomes the visible result.
         if (w_finish) begin
            r_result  <= w_fin_res;
            r_zero    <= (w_fin_res == '0);
            r_illegal <= w_fin_illegal;
         end
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.result    = r_result;
   assign bus.zero      = r_zero;
   assign bus.illegal   = r_illegal;
endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (WIDTH=32, SHIFT_STEP=1); multiply checks
// are included when SEQ_ALU_MUL_EN is defined.
module tb_seq_alu;
   localparam int unsigned W    = 32;
   localparam int unsigned STEP = 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   seq_alu_if #(.WIDTH(W)) bus ();
   seq_alu #(.WIDTH(W), .SHIFT_STEP(STEP)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic [W-1:0] res;
      logic         zero;
      logic         ill;
      int           lat;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   function automatic exp_t model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      int   sh;
      sh    = int'(b[4:0]);
      e.ill = 1'b0;
      e.lat = 1;
      case (c)
         4'b0010: e.res = a + b;
         4'b0110: e.res = a - b;
         4'b0000: e.res = a & b;
         4'b0001: e.res = a | b;
         4'b0011: e.res = a ^ b;
         4'b0111: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'b1000: e.res = (a < b) ? 32'd1 : 32'd0;
         4'b0100: begin e.res = a << sh; e.lat = 1 + (sh + STEP - 1) / STEP; end
         4'b0101: begin e.res = a >> sh; e.lat = 1 + (sh + STEP - 1) / STEP; end
         4'b1101: begin e.res = W'($signed(a) >>> sh); e.lat = 1 + (sh + STEP - 1) / STEP; end
`ifdef SEQ_ALU_MUL_EN
         4'b1010: begin e.res = a * b; e.lat = W + 1; end
`endif
         default: begin e.res = 32'h0000CAFE; e.ill = 1'b1; end
      endcase
      e.zero = (e.res == '0);
      return e;
   endfunction

   // Issue one op, check latency/busy behaviour, result, then optionally stall the consumer.
   task automatic run_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int hold, input string name);
      exp_t e;
      int   lat;
      bit   busy_bad;
      @(negedge clk);
      n_vec++;
      if (bus.in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL %s in_ready_idle got=%b want=1", name, bus.in_ready);
      end
      bus.in_valid = 1'b1;
      bus.control  = c;
      bus.input1   = a;
      bus.input2   = b;
      sb.push_back(model(c, a, b));
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.control  = 4'($urandom);
      bus.input1   = $urandom;
      bus.input2   = $urandom;
      lat      = 0;
      busy_bad = 1'b0;
      while (lat < 100) begin
         @(negedge clk);
         lat++;
         if (bus.out_valid === 1'b1) break;
         if (bus.in_ready !== 1'b0) busy_bad = 1'b1;
      end
      e = sb.pop_front();
      n_vec++;
      if (busy_bad) begin
         n_err++;
         $display("FAIL %s in_ready_busy got=1 want=0", name);
      end
      n_vec++;
      if (lat !== e.lat || bus.out_valid !== 1'b1) begin
         n_err++;
         $display("FAIL %s latency got=%0d want=%0d", name, lat, e.lat);
      end
      n_vec++;
      if (bus.result !== e.res || bus.zero !== e.zero || bus.illegal !== e.ill) begin
         n_err++;
         $display("FAIL %s result got=%h/z%b/i%b want=%h/z%b/i%b", name,
                  bus.result, bus.zero, bus.illegal, e.res, e.zero, e.ill);
      end
      for (int i = 0; i < hold; i++) begin
         bus.in_valid = 1'b1;
         @(negedge clk);
         n_vec++;
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.result !== e.res ||
             bus.zero !== e.zero) begin
            n_err++;
            $display("FAIL %s hold%0d got=v%b r%b %h want=v1 r0 %h", name, i,
                     bus.out_valid, bus.in_ready, bus.result, e.res);
         end
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      n_vec++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.result !== '0 || bus.zero !== 1'b1) begin
         n_err++;
         $display("FAIL reset got=r%b v%b %h z%b want=r1 v0 0 z1",
                  bus.in_ready, bus.out_valid, bus.result, bus.zero);
      end
   endtask

   task automatic test_arith();
      run_op(4'b0010, 32'd5, 32'd7, 0, "add");
      run_op(4'b0110, 32'd3, 32'd3, 0, "sub_zero");
      run_op(4'b0110, 32'd0, 32'd1, 0, "sub_wrap");
      run_op(4'b0010, 32'hFFFFFFFF, 32'd1, 0, "add_wrap");
      run_op(4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF, 0, "and");
      run_op(4'b0001, 32'hF000_0000, 32'h0000_000F, 0, "or");
      run_op(4'b0011, 32'hAAAA_5555, 32'hFFFF_FFFF, 0, "xor");
   endtask

   task automatic test_shift();
      run_op(4'b1101, 32'h8000_0000, 32'd4, 0, "sra4");
      run_op(4'b0101, 32'h8000_0000, 32'd4, 0, "srl4");
      run_op(4'b0100, 32'h0000_0001, 32'd31, 0, "sll31");
      run_op(4'b0100, 32'h1234_5678, 32'hFFFF_FFE0, 0, "sll0");
      run_op(4'b0101, 32'h8000_0000, 32'd31, 0, "srl31_nz");
      run_op(4'b0101, 32'h0000_0001, 32'd1, 0, "srl1_zero");
   endtask

   task automatic test_compare_illegal();
      run_op(4'b0111, 32'hFFFF_FFFF, 32'd1, 0, "slt");
      run_op(4'b1000, 32'hFFFF_FFFF, 32'd1, 0, "sltu");
      run_op(4'b1111, 32'd9, 32'd9, 0, "illegal_1111");
      run_op(4'b1010, 32'd3, 32'd4, 0, "op_1010");
   endtask

   task automatic test_hold();
      run_op(4'b0010, 32'd100, 32'd23, 3, "hold_add");
   endtask

   task automatic test_reset_mid();
      bit seen;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.control  = 4'b0100;
      bus.input1   = 32'd1;
      bus.input2   = 32'd20;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      n_vec++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.result !== '0 || bus.zero !== 1'b1) begin
         n_err++;
         $display("FAIL rst_mid got=r%b v%b %h z%b want=r1 v0 0 z1",
                  bus.in_ready, bus.out_valid, bus.result, bus.zero);
      end
      rst  = 1'b0;
      seen = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (bus.out_valid !== 1'b0) seen = 1'b1;
      end
      n_vec++;
      if (seen) begin
         n_err++;
         $display("FAIL rst_mid_no_output got=out_valid_seen want=none");
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] ops [11];
      ops = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0011, 4'b0111,
              4'b1000, 4'b0100, 4'b0101, 4'b1101, 4'b1011};
      for (int i = 0; i < 24; i++) begin
         run_op(ops[$urandom_range(0, 10)], $urandom, $urandom, 0, "random");
      end
   endtask

`ifdef SEQ_ALU_MUL_EN
   task automatic test_mul();
      run_op(4'b1010, 32'h0001_0000, 32'h0001_0000, 0, "mul_wrap_zero");
      run_op(4'b1010, 32'd12345, 32'd6789, 0, "mul");
   endtask
`endif

   initial begin
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.control   = '0;
      bus.input1    = '0;
      bus.input2    = '0;
      test_reset();
      test_arith();
      test_shift();
      test_compare_illegal();
      test_hold();
      test_reset_mid();
      test_back_to_back();
`ifdef SEQ_ALU_MUL_EN
      test_mul();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end
endmodule
